// File: rtl/trace_pkg.sv
// Record layout shared by the retirement trace stage and its consumers.
// One record = {pc, inst, rf_we, rf_waddr, rf_wdata}, pc in the MSBs.
package trace_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned RD_W   = 32;
  localparam int unsigned REC_W  = PC_W + INST_W + 1 + RA_W + RD_W;

  localparam int unsigned WDATA_LSB = 0;
  localparam int unsigned WADDR_LSB = WDATA_LSB + RD_W;
  localparam int unsigned WE_LSB    = WADDR_LSB + RA_W;
  localparam int unsigned INST_LSB  = WE_LSB + 1;
  localparam int unsigned PC_LSB    = INST_LSB + INST_W;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [PC_W-1:0]   rec_pc,
    input logic [INST_W-1:0] rec_inst,
    input logic              rec_we,
    input logic [RA_W-1:0]   rec_waddr,
    input logic [RD_W-1:0]   rec_wdata
  );
    return {rec_pc, rec_inst, rec_we, rec_waddr, rec_wdata};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head: dout always shows the oldest
// entry, and keeps the last popped value once the FIFO runs empty.
module sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_next;
  logic [ADDR_W:0]   count_next;
  logic [WIDTH-1:0]  head_next;
  logic              do_push;
  logic              do_pop;

  // Pop only a real entry; a push into a full FIFO survives only alongside a pop.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_next    = rd_ptr + ADDR_W'(do_pop);
    count_next = count + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    head_next  = dout;
    if (do_push && (count == (ADDR_W+1)'(do_pop))) begin
      head_next = din;
    end else if (count_next != '0) begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + ADDR_W'(do_push);
      count  <= count_next;
      dout   <= head_next;
      full   <= (count_next == (ADDR_W+1)'(DEPTH));
      empty  <= (count_next == '0);
    end
  end

endmodule

// File: rtl/retire_trace_capture.sv
// Retirement trace capture: detects PC changes, attaches the last GPR write of
// the outgoing instruction and queues one record per retirement.
module retire_trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst,
  input  logic              rf_we,
  input  logic [RA_W-1:0]   rf_waddr,
  input  logic [RD_W-1:0]   rf_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [PC_W-1:0]   trace_pc,
  output logic [INST_W-1:0] trace_inst,
  output logic              trace_rf_we,
  output logic [RA_W-1:0]   trace_rf_waddr,
  output logic [RD_W-1:0]   trace_rf_wdata,
  output logic [ADDR_W:0]   fifo_count,
  output logic [15:0]       overflow_cnt
);

  logic [PC_W-1:0]   prev_pc;
  logic [INST_W-1:0] prev_inst;
  logic              wb_pending;
  logic [RA_W-1:0]   wb_addr;
  logic [RD_W-1:0]   wb_data;
  logic              started;

  logic              pc_change;
  logic              wr_hit;
  logic              rec_we;
  logic [RA_W-1:0]   rec_addr;
  logic [RD_W-1:0]   rec_data;
  logic              push_req;
  logic              pop_req;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  rec_in;
  logic [REC_W-1:0]  rec_out;

  // A write landing on the retiring cycle belongs to the outgoing instruction.
  always_comb begin
    pc_change = (pc != prev_pc);
    wr_hit    = rf_we && (rf_waddr != '0);
    rec_we    = wb_pending;
    rec_addr  = wb_addr;
    rec_data  = wb_data;
    if (wr_hit) begin
      rec_we   = 1'b1;
      rec_addr = rf_waddr;
      rec_data = rf_wdata;
    end
    rec_in   = pack_rec(prev_pc, prev_inst, rec_we, rec_addr, rec_data);
    push_req = pc_change && enable && started;
    pop_req  = trace_valid && trace_ready;
    drop     = push_req && fifo_full && !pop_req;
  end

  // Change detector, writeback latch and start gating.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_pc    <= '0;
      prev_inst  <= '0;
      wb_pending <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      started    <= 1'b0;
    end else begin
      prev_inst <= inst;
      if (pc_change) begin
        prev_pc    <= pc;
        wb_pending <= 1'b0;
        wb_addr    <= '0;
        wb_data    <= '0;
      end else if (wr_hit) begin
        wb_pending <= 1'b1;
        wb_addr    <= rf_waddr;
        wb_data    <= rf_wdata;
      end
      if (!enable) begin
        started <= 1'b0;
      end else if (pc_change) begin
        started <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH  (REC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (push_req),
    .pop    (trace_ready),
    .din    (rec_in),
    .dout   (rec_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign trace_valid    = !fifo_empty;
  assign trace_pc       = rec_out[PC_LSB +: PC_W];
  assign trace_inst     = rec_out[INST_LSB +: INST_W];
  assign trace_rf_we    = rec_out[WE_LSB];
  assign trace_rf_waddr = rec_out[WADDR_LSB +: RA_W];
  assign trace_rf_wdata = rec_out[WDATA_LSB +: RD_W];

endmodule

// File: tb/tb_retire_trace_capture.sv
// Bench for retire_trace_capture: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_retire_trace_capture;

  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst = '0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic        trace_rf_we;
  logic [4:0]  trace_rf_waddr;
  logic [31:0] trace_rf_wdata;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_cnt;

  always #5 clk_in = ~clk_in;

  retire_trace_capture #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .enable         (enable),
    .pc             (pc),
    .inst           (inst),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_inst     (trace_inst),
    .trace_rf_we    (trace_rf_we),
    .trace_rf_waddr (trace_rf_waddr),
    .trace_rf_wdata (trace_rf_wdata),
    .fifo_count     (fifo_count),
    .overflow_cnt   (overflow_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of retired records plus the last one handed out.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } rec_t;

  rec_t        mq[$];
  rec_t        m_last = '{32'h0, 32'h0, 1'b0, 5'h0, 32'h0};
  rec_t        exp_h;
  int          m_ovf = 0;
  logic [31:0] m_prev_pc = '0;
  logic [31:0] m_prev_inst = '0;
  bit          m_wb = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  bit          m_started = 1'b0;

  always @(posedge clk_in) begin
    rec_t r;
    int   sz;
    bit   pop, chg, wr, want_push;
    if (reset) begin
      mq.delete();
      m_last      = '{32'h0, 32'h0, 1'b0, 5'h0, 32'h0};
      m_ovf       = 0;
      m_prev_pc   = '0;
      m_prev_inst = '0;
      m_wb        = 1'b0;
      m_wa        = '0;
      m_wd        = '0;
      m_started   = 1'b0;
    end else begin
      sz        = mq.size();
      pop       = (sz > 0) && trace_ready;
      chg       = (pc != m_prev_pc);
      wr        = rf_we && (rf_waddr != 5'd0);
      want_push = chg && enable && m_started;
      r.pc      = m_prev_pc;
      r.inst    = m_prev_inst;
      r.we      = wr || m_wb;
      r.a       = wr ? rf_waddr : (m_wb ? m_wa : 5'd0);
      r.d       = wr ? rf_wdata : (m_wb ? m_wd : 32'd0);
      if (pop) m_last = mq.pop_front();
      if (want_push) begin
        if (sz == DEPTH && !pop) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          mq.push_back(r);
        end
      end
      if (chg) m_wb = 1'b0;
      else if (wr) begin
        m_wb = 1'b1;
        m_wa = rf_waddr;
        m_wd = rf_wdata;
      end
      if (!enable) m_started = 1'b0;
      else if (chg) m_started = 1'b1;
      m_prev_inst = inst;
      if (chg) m_prev_pc = pc;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (checking) begin
      exp_h = (mq.size() > 0) ? mq[0] : m_last;
      check("valid", trace_valid, mq.size() > 0);
      check("count", fifo_count, mq.size());
      check("overflow", overflow_cnt, m_ovf);
      check("pc", trace_pc, exp_h.pc);
      check("inst", trace_inst, exp_h.inst);
      check("we", trace_rf_we, exp_h.we);
      check("waddr", trace_rf_waddr, exp_h.a);
      check("wdata", trace_rf_wdata, exp_h.d);
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_head(input string name, input logic [31:0] epc, input logic ewe,
                            input logic [4:0] ea, input logic [31:0] ed);
    check({name, "_pc"}, trace_pc, epc);
    check({name, "_we"}, trace_rf_we, ewe);
    check({name, "_waddr"}, trace_rf_waddr, ea);
    check({name, "_wdata"}, trace_rf_wdata, ed);
  endtask

  int rp;
  int rp_tab[8] = '{50, 10, 90, 0, 70, 30, 100, 50};

  initial begin
    // 1: first change suppressed, one record with the $1 write
    reset = 1'b1;
    enable = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    checking = 1'b1;
    check("rst_valid", trace_valid, 1'b0);
    check("rst_count", fifo_count, 5'd0);
    check("rst_ovf", overflow_cnt, 16'd0);
    check_head("rst", 32'h0, 1'b0, 5'd0, 32'h0);
    cyc();
    pc = 32'h0040_0000;
    inst = 32'h3C01_0001;
    cyc();
    check("t1_first_change", fifo_count, 5'd0);
    rf_we = 1'b1;
    rf_waddr = 5'd1;
    rf_wdata = 32'h0001_0000;
    cyc();
    rf_we = 1'b0;
    pc = 32'h0040_0004;
    inst = 32'h0000_0820;
    cyc();
    check("t1_count", fifo_count, 5'd1);
    check("t1_valid", trace_valid, 1'b1);
    check("t1_inst", trace_inst, 32'h3C01_0001);
    check_head("t1", 32'h0040_0000, 1'b1, 5'd1, 32'h0001_0000);

    // 2: write to $0 is not recorded
    rf_we = 1'b1;
    rf_waddr = 5'd0;
    rf_wdata = 32'hDEAD_BEEF;
    cyc();
    rf_we = 1'b0;
    pc = 32'h0040_0008;
    cyc();
    check("t2_count", fifo_count, 5'd2);
    trace_ready = 1'b1;
    cyc();
    check("t2_valid", trace_valid, 1'b1);
    check_head("t2", 32'h0040_0004, 1'b0, 5'd0, 32'h0);
    cyc();
    trace_ready = 1'b0;
    check("t2_empty_valid", trace_valid, 1'b0);
    check("t2_empty_count", fifo_count, 5'd0);
    check("t2_hold_pc", trace_pc, 32'h0040_0004);

    // 3: 20 retirements into a 16-deep FIFO
    for (int k = 1; k <= 20; k++) begin
      pc = 32'h0040_0008 + 32'(4 * k);
      inst = 32'(k);
      cyc();
    end
    check("t3_count", fifo_count, 5'd16);
    check("t3_ovf", overflow_cnt, 16'd4);

    // 4: push and pop together while full
    trace_ready = 1'b1;
    pc = 32'h0040_005C;
    cyc();
    trace_ready = 1'b0;
    check("t4_count", fifo_count, 5'd16);
    check("t4_ovf", overflow_cnt, 16'd4);
    check("t4_head", trace_pc, 32'h0040_000C);
    trace_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("t3_drain_pc", trace_pc, (k < 15) ? 32'h0040_000C + 32'(4 * k) : 32'h0040_0058);
      cyc();
    end
    trace_ready = 1'b0;
    check("t3_drained", fifo_count, 5'd0);

    // 5: write on the retiring cycle goes with the outgoing instruction
    pc = 32'h0040_0060;
    rf_we = 1'b1;
    rf_waddr = 5'd2;
    rf_wdata = 32'h0000_0005;
    cyc();
    rf_we = 1'b0;
    pc = 32'h0040_0064;
    cyc();
    check("t5_count", fifo_count, 5'd2);
    check_head("t5a", 32'h0040_005C, 1'b1, 5'd2, 32'h5);
    trace_ready = 1'b1;
    cyc();
    trace_ready = 1'b0;
    check_head("t5b", 32'h0040_0060, 1'b0, 5'd0, 32'h0);

    // 6: reset with entries queued
    for (int k = 0; k < 4; k++) begin
      pc = pc + 32'd4;
      cyc();
    end
    check("t6_count_before", fifo_count, 5'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_valid", trace_valid, 1'b0);
    check("t6_count", fifo_count, 5'd0);
    check("t6_ovf", overflow_cnt, 16'd0);
    pc = 32'h0040_0100;
    cyc();
    check("t6_first_change", fifo_count, 5'd0);
    pc = 32'h0040_0104;
    cyc();
    check("t6_count_after", fifo_count, 5'd1);
    check("t6_head", trace_pc, 32'h0040_0100);

    // Randomized traffic: enable toggles, resets, bursts, varying drain rates
    for (int i = 0; i < 4000; i++) begin
      rp = rp_tab[(i / 500) % 8];
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      trace_ready = ($urandom_range(0, 99) < rp);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 19) == 0) pc = $urandom;
        else pc = pc + 32'd4;
      end
      if ($urandom_range(0, 1) == 0) inst = $urandom;
      rf_we = ($urandom_range(0, 3) == 0);
      rf_waddr = 5'($urandom);
      rf_wdata = $urandom;
      cyc();
    end
    reset = 1'b0;
    rf_we = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/retire_trace_capture.md
Name: retire_trace_capture

Overview:
- Synthesizable retirement-trace stage that sits directly downstream of sccomp_dataflow.
- Consumes the SoC's pc, inst and register-file write port.
- Emits one record per retired instruction, {pc, inst, last GPR write}, into a FIFO drained by a valid/ready consumer (UART dumper, on-chip logic analyser).
- Replaces the simulation-only per-PC-change register dump with on-chip capture.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
ADDR_W, 4, log2(DEPTH)

Ports:
clk_in  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable; low suppresses all pushes
pc  in  32  current PC from sccomp_dataflow
inst  in  32  current instruction from sccomp_dataflow
rf_we  in  1  register-file write strobe, one cycle per write
rf_waddr  in  5  register-file write address
rf_wdata  in  32  register-file write data
trace_valid  out  1  head record available
trace_ready  in  1  consumer accepts head record
trace_pc  out  32  retired instruction address
trace_inst  out  32  retired instruction word
trace_rf_we  out  1  retired instruction wrote a GPR
trace_rf_waddr  out  5  GPR written; 0 when trace_rf_we=0
trace_rf_wdata  out  32  value written; 0 when trace_rf_we=0
fifo_count  out  ADDR_W+1  occupied entries, 0..DEPTH
overflow_cnt  out  16  dropped records, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0; internal prev_pc=0, prev_inst=0, wb_pending=0, started=0; FIFO empty. Reset mid-operation discards all FIFO contents and the pending record.
- Tracking runs every cycle regardless of enable:
  - pc_change = (pc != prev_pc).
  - On pc_change: prev_pc<=pc, prev_inst<=inst.
  - Otherwise: prev_inst<=inst. The last inst seen before a change is what gets recorded, which tolerates multicycle fetch.
- Writeback capture:
  - rf_we=1 with rf_waddr!=0 latches wb_pending=1 plus addr/data; last write wins.
  - Writes to $0 are ignored.
  - rf_we in the same cycle as pc_change belongs to the outgoing instruction.
- Push, on pc_change:
  - Record = {prev_pc, prev_inst, wb_pending, wb_addr, wb_data}, with the same-cycle write merged in.
  - Pushed only if enable=1 and started=1.
  - The first pc_change after reset, or after enable rises, only sets started=1. This suppresses the bogus pc=0 record.
  - wb_pending clears on every pc_change, pushed or not.
- enable=0: started<=0, no pushes, overflow_cnt holds.
- FIFO:
  - Registered; a record pushed at edge N is visible with trace_valid=1 after edge N.
  - Pop occurs when trace_valid && trace_ready.
  - Outputs stay stable while trace_valid=1 && trace_ready=0.
- Full: a push with fifo_count==DEPTH and no pop that cycle is dropped and overflow_cnt increments (saturating). Push and pop together while full: both are accepted and the count is unchanged.
- Empty: trace_valid=0, data outputs hold their last popped value, trace_ready is ignored. Push and pop together while empty: only the push takes effect.
- fifo_count = pushes − pops, never exceeding DEPTH; pointers wrap modulo DEPTH.

Decomposition:
- Package trace_pkg holds:
  - field widths PC_W=32, INST_W=32, RA_W=5, RD_W=32;
  - REC_W=102;
  - field offsets for packing/unpacking the record vector.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count; same clk_in/reset convention), is the natural split.
- retire_trace_capture keeps the change detector, writeback latch, start/enable control and overflow counter.

Test Plan:
1. Reset, enable=1; pc 0→00400000→00400004, inst 3C010001 at 00400000, rf_we at $1 ← 00010000 → exactly one record: {00400000, 3C010001, we=1, 1, 00010000}; first change suppressed.
2. Instruction with rf_we to $0 only, data DEADBEEF → record has trace_rf_we=0, addr=0, data=0.
3. trace_ready=0, DEPTH=16, 20 retirements → fifo_count=16, overflow_cnt=4; then drain → 16 records in PC order, oldest first.
4. Full FIFO, push and pop in the same cycle → fifo_count stays 16, overflow_cnt unchanged, new record appears last.
5. rf_we $2←00000005 in the same cycle pc changes → the write is attached to the outgoing record, and the next record shows we=0 unless it writes.
6. Assert reset with 5 entries queued → next cycle trace_valid=0, fifo_count=0, overflow_cnt=0; the first post-reset change produces no record.
